pwm_update_sched: RTL and testbench

//  Sits between spi_slave and the pwm channel array. Decodes each received SPI frame
//  (channel select + threshold) into a per-channel shadow register. Commits pending

---
 rtl/pulsar_pkg.sv | 21 ++
 rtl/pwm_shadow_chan.sv | 69 ++++++
 rtl/pwm_update_sched.sv | 65 ++++++
 tb/tb_pwm_update_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulsar_pkg.sv
// Shared types and width helpers for the pulsar PWM datapath.
// The SPI frame is a byte-aligned channel select field above a pwm_width threshold.
package pulsar_pkg;

   typedef enum logic [1:0] {IDLE, ARMED, COMMIT} chan_state_t;

   // Select field width: whole bytes covering $clog2(num_pwm), never narrower than one byte.
   function automatic int sel_bits(input int num_pwm);
      int pwm_bits;
      int bytes;
      pwm_bits = $clog2(num_pwm);
      bytes    = (pwm_bits + 7) / 8;
      if (bytes == 0) bytes = 1;
      return 8 * bytes;
   endfunction

   function automatic int spi_width(input int pwm_width, input int num_pwm);
      return pwm_width + sel_bits(num_pwm);
   endfunction

endpackage

// File: rtl/pwm_shadow_chan.sv
// One PWM channel: shadow threshold, pending lifecycle and the committed slice.
// Commits on overflow when synchronised, otherwise on the edge after each write.
module pwm_shadow_chan
   import pulsar_pkg::*;
#(
   parameter int pwm_width    = 16,
   parameter bit sync_updates = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [pwm_width-1:0] wr_data,
   input  logic                 overflow,
   output logic                 set_thres,
   output logic [pwm_width-1:0] new_thres,
   output logic                 pending
);

   chan_state_t          state_q, state_d;
   logic [pwm_width-1:0] shadow_q, shadow_d;
   logic [pwm_width-1:0] slice_q, slice_d;
   logic                 set_q, set_d;
   logic                 commit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         slice_q  <= '0;
         set_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         slice_q  <= slice_d;
         set_q    <= set_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shadow_d = wr_en ? wr_data : shadow_q;
      slice_d  = slice_q;
      commit   = 1'b0;
      if (!sync_updates) begin
         commit  = wr_en;
         state_d = wr_en ? COMMIT : IDLE;
         if (wr_en) slice_d = wr_data;
      end else begin
         case (state_q)
            ARMED: begin
               if (overflow) begin
                  // The value committed is the one held before this edge; a write
                  // landing on the same edge stays armed for the next overflow.
                  commit  = 1'b1;
                  slice_d = shadow_q;
                  state_d = wr_en ? ARMED : COMMIT;
               end
            end
            default: state_d = wr_en ? ARMED : IDLE;
         endcase
      end
      set_d = commit;
   end

   assign set_thres = set_q;
   assign new_thres = slice_q;
   assign pending   = (state_q == ARMED);

endmodule

// File: rtl/pwm_update_sched.sv
// Decodes SPI frames into per-channel shadow registers and schedules their commit
// to the PWM channels; out-of-range selects set a sticky error flag.
module pwm_update_sched
   import pulsar_pkg::*;
#(
   parameter int pwm_width    = 16,
   parameter int num_pwm      = 2,
   parameter bit sync_updates = 1'b1
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        cmd_valid,
   input  logic [spi_width(pwm_width, num_pwm)-1:0]    cmd_data,
   input  logic                                        overflow,
   output logic [num_pwm-1:0]                          set_thres,
   output logic [num_pwm*pwm_width-1:0]                new_thres,
   output logic [num_pwm-1:0]                          pending,
   output logic                                        cmd_err
);

   localparam int SEL_W = sel_bits(num_pwm);
   localparam int SPI_W = spi_width(pwm_width, num_pwm);
   localparam logic [SEL_W:0] NUM_EXT = (SEL_W + 1)'(num_pwm);

   logic [SEL_W-1:0]     sel;
   logic [pwm_width-1:0] thres;
   logic                 sel_ok;
   logic                 cmd_err_q, cmd_err_d;
   logic [num_pwm-1:0]   wr_en;

   assign sel    = cmd_data[SPI_W-1:pwm_width];
   assign thres  = cmd_data[pwm_width-1:0];
   assign sel_ok = ({1'b0, sel} < NUM_EXT);

   assign cmd_err_d = cmd_err_q | (cmd_valid & ~sel_ok);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cmd_err_q <= 1'b0;
      else       cmd_err_q <= cmd_err_d;
   end

   assign cmd_err = cmd_err_q;

   genvar gi;
   generate
      for (gi = 0; gi < num_pwm; gi++) begin : g_chan
         assign wr_en[gi] = cmd_valid & sel_ok & (sel == SEL_W'(gi));

         pwm_shadow_chan #(
            .pwm_width   (pwm_width),
            .sync_updates(sync_updates)
         ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (wr_en[gi]),
            .wr_data  (thres),
            .overflow (overflow),
            .set_thres(set_thres[gi]),
            .new_thres(new_thres[gi*pwm_width +: pwm_width]),
            .pending  (pending[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_pwm_update_sched.sv
// Scoreboard bench: a reference model pushes expected commits as stimulus is driven,
// monitors pop and compare whenever a DUT raises a load strobe.
module tb_pwm_update_sched;

   typedef struct packed {
      logic [1:0]  set;
      logic [31:0] nt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0, cmd_valid0 = 1'b0;
   logic [23:0] cmd_data = '0, cmd_data0 = '0;
   logic        overflow = 1'b0, overflow0 = 1'b0;
   logic [1:0]  set_thres, set_thres0;
   logic [31:0] new_thres, new_thres0;
   logic [1:0]  pending, pending0;
   logic        cmd_err, cmd_err0;

   int errors = 0;
   int checks = 0;

   exp_t q1[$];
   exp_t q0[$];

   // reference model state (sync DUT and async DUT)
   logic [15:0] m_shadow [2];
   logic [15:0] m_slice  [2];
   logic [1:0]  m_pend;
   logic        m_err;
   logic [15:0] m_slice0 [2];

   always #5 clk = ~clk;

   pwm_update_sched #(.pwm_width(16), .num_pwm(2), .sync_updates(1'b1)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
      .overflow(overflow), .set_thres(set_thres), .new_thres(new_thres),
      .pending(pending), .cmd_err(cmd_err)
   );

   pwm_update_sched #(.pwm_width(16), .num_pwm(2), .sync_updates(1'b0)) dut0 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid0), .cmd_data(cmd_data0),
      .overflow(overflow0), .set_thres(set_thres0), .new_thres(new_thres0),
      .pending(pending0), .cmd_err(cmd_err0)
   );

   function automatic logic [31:0] pack_slices(input logic [15:0] s0, input logic [15:0] s1);
      return {s1, s0};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_shadow[i] = '0;
         m_slice[i]  = '0;
         m_slice0[i] = '0;
      end
      m_pend = '0;
      m_err  = 1'b0;
   endtask

   // One clock of stimulus to the synchronised DUT, with the model advanced alongside.
   task automatic cyc(input logic v, input logic [23:0] d, input logic ovf);
      exp_t e;
      logic [1:0] p;
      p = m_pend;
      if (ovf && p != 2'b00) begin
         for (int i = 0; i < 2; i++)
            if (p[i]) m_slice[i] = m_shadow[i];
         e.set = p;
         e.nt  = pack_slices(m_slice[0], m_slice[1]);
         q1.push_back(e);
         m_pend = m_pend & ~p;
      end
      if (v) begin
         if (d[23:16] < 8'd2) begin
            m_shadow[d[16]] = d[15:0];
            m_pend[d[16]]   = 1'b1;
         end else begin
            m_err = 1'b1;
         end
      end
      cmd_valid = v;
      cmd_data  = d;
      overflow  = ovf;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_data  = '0;
      overflow  = 1'b0;
   endtask

   task automatic cyc0(input logic v, input logic [23:0] d, input logic ovf);
      exp_t e;
      if (v && d[23:16] < 8'd2) begin
         m_slice0[d[16]] = d[15:0];
         e.set = 2'b01 << d[16];
         e.nt  = pack_slices(m_slice0[0], m_slice0[1]);
         q0.push_back(e);
      end
      cmd_valid0 = v;
      cmd_data0  = d;
      overflow0  = ovf;
      @(posedge clk);
      #1;
      cmd_valid0 = 1'b0;
      cmd_data0  = '0;
      overflow0  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 24'h0, 1'b0);
   endtask

   // Scoreboard monitors sample on the falling edge, away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && set_thres != 2'b00) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL sync_strobe: unexpected set_thres=%b new_thres=%h", set_thres, new_thres);
         end else begin
            e = q1.pop_front();
            if (set_thres !== e.set || new_thres !== e.nt) begin
               errors++;
               $display("FAIL sync_strobe: got set=%b nt=%h, want set=%b nt=%h",
                        set_thres, new_thres, e.set, e.nt);
            end else begin
               $display("sync commit set=%b new_thres=%h", set_thres, new_thres);
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset && set_thres0 != 2'b00) begin
         checks++;
         if (q0.size() == 0) begin
            errors++;
            $display("FAIL async_strobe: unexpected set_thres=%b new_thres=%h", set_thres0, new_thres0);
         end else begin
            e = q0.pop_front();
            if (set_thres0 !== e.set || new_thres0 !== e.nt) begin
               errors++;
               $display("FAIL async_strobe: got set=%b nt=%h, want set=%b nt=%h",
                        set_thres0, new_thres0, e.set, e.nt);
            end else begin
               $display("async commit set=%b new_thres=%h", set_thres0, new_thres0);
            end
         end
      end
   end

   task automatic expect_drained(input string name);
      checks++;
      if (q1.size() != 0 || q0.size() != 0) begin
         errors++;
         $display("FAIL %s: missing strobes, sync left=%0d async left=%0d, want 0", name, q1.size(), q0.size());
      end
   endtask

   task automatic test_reset();
      model_reset();
      #2;
      checks++;
      if ({set_thres, new_thres, pending, cmd_err} !== 37'h0) begin
         errors++;
         $display("FAIL reset_state: set=%b nt=%h pend=%b err=%b, want all 0", set_thres, new_thres, pending, cmd_err);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      idle(2);
      expect_drained("reset_quiet");
      $display("test_reset done");
   endtask

   task automatic test_basic_commit();
      cyc(1'b1, 24'h001234, 1'b0);
      idle(10);
      checks++;
      if (pending !== m_pend || set_thres !== 2'b00) begin
         errors++;
         $display("FAIL basic_pending: pend=%b set=%b, want pend=%b set=00", pending, set_thres, m_pend);
      end
      cyc(1'b0, 24'h0, 1'b1);
      checks++;
      if (pending !== 2'b00) begin
         errors++;
         $display("FAIL basic_cleared: pend=%b, want 00", pending);
      end
      idle(2);
      expect_drained("basic_commit");
   endtask

   task automatic test_last_writer();
      cyc(1'b1, 24'h010100, 1'b0);
      cyc(1'b1, 24'h010200, 1'b0);
      checks++;
      if (pending !== 2'b10) begin
         errors++;
         $display("FAIL lastwr_pending: pend=%b, want 10", pending);
      end
      cyc(1'b0, 24'h0, 1'b1);
      idle(3);
      expect_drained("last_writer");
   endtask

   task automatic test_back_to_back();
      cyc(1'b1, 24'h01AAAA, 1'b0);
      cyc(1'b1, 24'h005555, 1'b1);
      checks++;
      if (pending !== 2'b01) begin
         errors++;
         $display("FAIL b2b_pending: pend=%b, want 01", pending);
      end
      idle(2);
      cyc(1'b0, 24'h0, 1'b1);
      idle(2);
      expect_drained("back_to_back");
      // empty overflow must not strobe
      cyc(1'b0, 24'h0, 1'b1);
      idle(2);
      expect_drained("idle_overflow");
   endtask

   task automatic test_cmd_err();
      cyc(1'b1, 24'h05FFFF, 1'b0);
      checks++;
      if (cmd_err !== 1'b1 || pending !== 2'b00 || new_thres !== pack_slices(m_slice[0], m_slice[1])) begin
         errors++;
         $display("FAIL err_reject: err=%b pend=%b nt=%h, want err=1 pend=00 nt=%h",
                  cmd_err, pending, new_thres, pack_slices(m_slice[0], m_slice[1]));
      end
      cyc(1'b1, 24'h010001, 1'b0);
      cyc(1'b1, 24'h000002, 1'b0);
      checks++;
      if (cmd_err !== m_err || pending !== m_pend) begin
         errors++;
         $display("FAIL err_sticky: err=%b pend=%b, want err=%b pend=%b", cmd_err, pending, m_err, m_pend);
      end
   endtask

   task automatic test_async_reset();
      checks++;
      if (pending !== 2'b11) begin
         errors++;
         $display("FAIL rst_setup: pend=%b, want 11", pending);
      end
      #2 reset = 1'b1;
      #1;
      model_reset();
      checks++;
      if ({set_thres, new_thres, pending, cmd_err} !== 37'h0) begin
         errors++;
         $display("FAIL async_reset: set=%b nt=%h pend=%b err=%b, want all 0", set_thres, new_thres, pending, cmd_err);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      cyc(1'b0, 24'h0, 1'b1);
      idle(2);
      expect_drained("post_reset_overflow");
   endtask

   task automatic test_unsync();
      cyc0(1'b1, 24'h01BEEF, 1'b0);
      checks++;
      if (set_thres0 !== 2'b10 || new_thres0[31:16] !== 16'hBEEF || pending0 !== 2'b00) begin
         errors++;
         $display("FAIL unsync_commit: set=%b slice1=%h pend=%b, want set=10 slice1=beef pend=00",
                  set_thres0, new_thres0[31:16], pending0);
      end
      cyc0(1'b0, 24'h0, 1'b1);
      cyc0(1'b0, 24'h0, 1'b1);
      cyc0(1'b1, 24'h004321, 1'b1);
      cyc0(1'b0, 24'h0, 1'b0);
      expect_drained("unsync");
   endtask

   initial begin
      test_reset();
      test_basic_commit();
      test_last_writer();
      test_back_to_back();
      test_cmd_err();
      test_async_reset();
      test_unsync();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
